// File: rtl/ysyx_22050550_pkg.sv
// Shared definitions for the single-issue execution controller.
// State encodings, widths, reset defaults and the writeback latch.
package ysyx_22050550_pkg;

  localparam int XLEN = 64;
  localparam int ILEN = 32;
  localparam int RLEN = 5;
  localparam int WLEN = 8;

  localparam logic [XLEN-1:0] RESET_PC_DEF = 64'h8000_0000;
  localparam logic [WLEN-1:0] WDOG_MAX_DEF = 8'd255;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    FETCH = 3'd1,
    EXEC  = 3'd2,
    WB    = 3'd3,
    HALT  = 3'd4,
    ERR   = 3'd5
  } state_e;

  typedef struct packed {
    logic            wen;
    logic [RLEN-1:0] rd;
    logic [XLEN-1:0] wdata;
    logic            jmp;
    logic [XLEN-1:0] target;
  } wb_t;

  function automatic logic misaligned(
    input logic [XLEN-1:0] a
  );
    return a[1:0] != 2'b00;
  endfunction

endpackage

// File: rtl/ysyx_22050550_wdog.sv
// Per-state cycle counter; expired flags the last allowed cycle
// so the controller can leave for ERR on that edge.
module ysyx_22050550_wdog
  import ysyx_22050550_pkg::*;
#(
  parameter logic [WLEN-1:0] MAX = WDOG_MAX_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  logic [WLEN-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (clear) begin
      cnt <= '0;
    end else if (enable) begin
      cnt <= cnt + 8'd1;
    end
  end

  assign expired = enable && (cnt == MAX - 8'd1);

endmodule

// File: rtl/ysyx_22050550_exctrl.sv
// Multi-cycle fetch/execute/writeback sequencer with watchdog,
// misaligned-jump trap and ebreak halt.
module ysyx_22050550_exctrl
  import ysyx_22050550_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEF,
  parameter logic [WLEN-1:0] WDOG_MAX = WDOG_MAX_DEF
) (
  input  logic            clk,
  input  logic            rst,
  output logic            ifu_req_valid,
  output logic [XLEN-1:0] ifu_req_addr,
  input  logic            ifu_rsp_valid,
  input  logic [ILEN-1:0] ifu_rsp_inst,
  output logic            exu_valid,
  output logic [XLEN-1:0] exu_pc,
  output logic [ILEN-1:0] exu_instr,
  input  logic            exu_done,
  input  logic            exu_wen,
  input  logic [RLEN-1:0] exu_rd,
  input  logic [XLEN-1:0] exu_wdata,
  input  logic            exu_ebreak,
  input  logic            exu_jmp,
  input  logic [XLEN-1:0] exu_jmp_target,
  output logic            rf_wen,
  output logic [RLEN-1:0] rf_waddr,
  output logic [XLEN-1:0] rf_wdata,
  output logic            halt,
  output logic            err,
  output logic [XLEN-1:0] instret
);

  state_e          state_q;
  state_e          state_d;
  logic [XLEN-1:0] pc_q;
  logic [ILEN-1:0] inst_q;
  wb_t             wb_q;
  logic [XLEN-1:0] instret_q;
  logic            wd_clear;
  logic            wd_en;
  logic            wd_exp;
  logic            in_fetch;
  logic            in_exec;
  logic            in_wb;

  assign in_fetch = (state_q == FETCH);
  assign in_exec  = (state_q == EXEC);
  assign in_wb    = (state_q == WB);
  assign wd_en    = in_fetch || in_exec;

  ysyx_22050550_wdog #(
    .MAX(WDOG_MAX)
  ) u_wdog (
    .clk    (clk),
    .rst    (rst),
    .clear  (wd_clear),
    .enable (wd_en),
    .expired(wd_exp)
  );

  always_comb begin
    state_d  = state_q;
    wd_clear = 1'b0;
    unique case (state_q)
      IDLE:  state_d = FETCH;
      FETCH: begin
        if (ifu_rsp_valid)  state_d = EXEC;
        else if (wd_exp)    state_d = ERR;
      end
      EXEC: begin
        if (exu_done) begin
          if (exu_ebreak)
            state_d = HALT;
          else if (exu_jmp && misaligned(exu_jmp_target))
            state_d = ERR;
          else
            state_d = WB;
        end else if (wd_exp) begin
          state_d = ERR;
        end
      end
      WB:    state_d = FETCH;
      HALT:  state_d = HALT;
      ERR:   state_d = ERR;
      default: state_d = IDLE;
    endcase
    // Counter restarts on every entry into a waiting state.
    wd_clear = (state_d != state_q) &&
               ((state_d == FETCH) || (state_d == EXEC));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      pc_q      <= RESET_PC;
      inst_q    <= '0;
      wb_q      <= '0;
      instret_q <= '0;
    end else begin
      state_q <= state_d;
      if (in_fetch && ifu_rsp_valid) begin
        inst_q <= ifu_rsp_inst;
      end
      if (in_exec && exu_done) begin
        wb_q.wen    <= exu_wen;
        wb_q.rd     <= exu_rd;
        wb_q.wdata  <= exu_wdata;
        wb_q.jmp    <= exu_jmp;
        wb_q.target <= exu_jmp_target;
        // ebreak retires here since it never reaches WB.
        if (exu_ebreak) begin
          instret_q <= instret_q + 64'd1;
        end
      end
      if (in_wb) begin
        instret_q <= instret_q + 64'd1;
        pc_q      <= wb_q.jmp ? wb_q.target : pc_q + 64'd4;
      end
    end
  end

  assign ifu_req_valid = in_fetch;
  assign ifu_req_addr  = in_fetch ? pc_q : '0;
  assign exu_valid     = in_exec;
  assign exu_pc        = in_exec ? pc_q : '0;
  assign exu_instr     = in_exec ? inst_q : '0;
  assign rf_wen        = in_wb && wb_q.wen && (wb_q.rd != '0);
  assign rf_waddr      = in_wb ? wb_q.rd : '0;
  assign rf_wdata      = in_wb ? wb_q.wdata : '0;
  assign halt          = (state_q == HALT);
  assign err           = (state_q == ERR);
  assign instret       = instret_q;

endmodule

// File: tb/tb_ysyx_22050550_exctrl.sv
// Directed bench for the execution controller.
// Inputs change #1 after posedge; outputs are checked at that point.
module tb_ysyx_22050550_exctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        ifu_req_valid;
  logic [63:0] ifu_req_addr;
  logic        ifu_rsp_valid = 1'b0;
  logic [31:0] ifu_rsp_inst = '0;
  logic        exu_valid;
  logic [63:0] exu_pc;
  logic [31:0] exu_instr;
  logic        exu_done = 1'b0;
  logic        exu_wen = 1'b0;
  logic [4:0]  exu_rd = '0;
  logic [63:0] exu_wdata = '0;
  logic        exu_ebreak = 1'b0;
  logic        exu_jmp = 1'b0;
  logic [63:0] exu_jmp_target = '0;
  logic        rf_wen;
  logic [4:0]  rf_waddr;
  logic [63:0] rf_wdata;
  logic        halt;
  logic        err;
  logic [63:0] instret;

  int n_tests = 0;
  int n_fail  = 0;

  localparam logic [31:0] ADDI = 32'h0070_0293;

  ysyx_22050550_exctrl dut (
    .clk           (clk),
    .rst           (rst),
    .ifu_req_valid (ifu_req_valid),
    .ifu_req_addr  (ifu_req_addr),
    .ifu_rsp_valid (ifu_rsp_valid),
    .ifu_rsp_inst  (ifu_rsp_inst),
    .exu_valid     (exu_valid),
    .exu_pc        (exu_pc),
    .exu_instr     (exu_instr),
    .exu_done      (exu_done),
    .exu_wen       (exu_wen),
    .exu_rd        (exu_rd),
    .exu_wdata     (exu_wdata),
    .exu_ebreak    (exu_ebreak),
    .exu_jmp       (exu_jmp),
    .exu_jmp_target(exu_jmp_target),
    .rf_wen        (rf_wen),
    .rf_waddr      (rf_waddr),
    .rf_wdata      (rf_wdata),
    .halt          (halt),
    .err           (err),
    .instret       (instret)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic clr_in();
    ifu_rsp_valid  = 1'b0;
    ifu_rsp_inst   = '0;
    exu_done       = 1'b0;
    exu_wen        = 1'b0;
    exu_rd         = '0;
    exu_wdata      = '0;
    exu_ebreak     = 1'b0;
    exu_jmp        = 1'b0;
    exu_jmp_target = '0;
  endtask

  task automatic do_reset();
    clr_in();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  // Starts in FETCH; leaves the DUT in WB, HALT or ERR.
  task automatic do_insn(input logic wen, input logic [4:0] rd,
                         input logic [63:0] wd, input logic jmp,
                         input logic [63:0] tgt, input logic ebrk);
    ifu_rsp_valid = 1'b1;
    ifu_rsp_inst  = ADDI;
    tick();
    clr_in();
    exu_done       = 1'b1;
    exu_wen        = wen;
    exu_rd         = rd;
    exu_wdata      = wd;
    exu_jmp        = jmp;
    exu_jmp_target = tgt;
    exu_ebreak     = ebrk;
    tick();
    clr_in();
  endtask

  initial begin
    int busy;
    do_reset();
    chk("idle_req", ifu_req_valid, 0);
    chk("idle_addr", ifu_req_addr, 0);
    chk("idle_exu", exu_valid, 0);
    chk("idle_rfwen", rf_wen, 0);
    chk("idle_halt", halt, 0);
    chk("idle_err", err, 0);
    chk("idle_instret", instret, 0);

    tick();
    chk("f1_req", ifu_req_valid, 1);
    chk("f1_addr", ifu_req_addr, 64'h8000_0000);
    exu_done = 1'b1;
    tick();
    exu_done = 1'b0;
    chk("done_outside_exec", ifu_req_valid, 1);
    ifu_rsp_valid = 1'b1;
    ifu_rsp_inst  = ADDI;
    tick();
    clr_in();
    chk("e1_valid", exu_valid, 1);
    chk("e1_pc", exu_pc, 64'h8000_0000);
    chk("e1_instr", exu_instr, ADDI);
    chk("e1_noreq", ifu_req_valid, 0);
    exu_done  = 1'b1;
    exu_wen   = 1'b1;
    exu_rd    = 5'd5;
    exu_wdata = 64'd7;
    tick();
    clr_in();
    chk("wb1_wen", rf_wen, 1);
    chk("wb1_waddr", rf_waddr, 5);
    chk("wb1_wdata", rf_wdata, 7);
    chk("wb1_noexu", exu_valid, 0);
    tick();
    chk("f2_instret", instret, 1);
    chk("f2_addr", ifu_req_addr, 64'h8000_0004);
    chk("f2_rfwen", rf_wen, 0);

    do_insn(1'b1, 5'd0, 64'h55, 1'b0, 64'h0, 1'b0);
    chk("rd0_wen", rf_wen, 0);
    tick();
    chk("rd0_instret", instret, 2);
    chk("rd0_addr", ifu_req_addr, 64'h8000_0008);

    do_insn(1'b0, 5'd1, 64'h0, 1'b1, 64'h8000_0100, 1'b0);
    tick();
    chk("jmp_addr", ifu_req_addr, 64'h8000_0100);
    chk("jmp_instret", instret, 3);

    do_insn(1'b1, 5'd3, 64'h33, 1'b1, 64'h8000_0102, 1'b0);
    chk("mis_err", err, 1);
    chk("mis_rfwen", rf_wen, 0);
    busy = 0;
    for (int i = 0; i < 5; i++) begin
      ifu_rsp_valid = 1'b1;
      exu_done      = 1'b1;
      exu_wen       = 1'b1;
      exu_rd        = 5'd3;
      tick();
      if (ifu_req_valid || exu_valid || rf_wen) busy++;
    end
    clr_in();
    chk("mis_quiet", busy, 0);
    chk("mis_sticky", err, 1);
    chk("mis_instret", instret, 3);

    do_reset();
    tick();
    do_insn(1'b1, 5'd7, 64'h77, 1'b0, 64'h0, 1'b1);
    chk("eb_halt", halt, 1);
    chk("eb_rfwen", rf_wen, 0);
    chk("eb_instret", instret, 1);
    busy = 0;
    for (int i = 0; i < 20; i++) begin
      ifu_rsp_valid = 1'b1;
      exu_done      = 1'b1;
      tick();
      if (ifu_req_valid || exu_valid || rf_wen) busy++;
    end
    clr_in();
    chk("eb_quiet", busy, 0);
    chk("eb_sticky", halt, 1);
    chk("eb_instret2", instret, 1);
    do_reset();
    chk("eb_rst_halt", halt, 0);
    tick();
    chk("eb_rst_addr", ifu_req_addr, 64'h8000_0000);

    repeat (254) tick();
    chk("wd_254_err", err, 0);
    chk("wd_254_req", ifu_req_valid, 1);
    tick();
    chk("wd_255_err", err, 1);

    do_reset();
    tick();
    repeat (254) tick();
    ifu_rsp_valid = 1'b1;
    ifu_rsp_inst  = ADDI;
    tick();
    clr_in();
    chk("wd_late_exu", exu_valid, 1);
    chk("wd_late_err", err, 0);
    exu_done = 1'b1;
    tick();
    clr_in();
    tick();
    chk("wd_late_addr", ifu_req_addr, 64'h8000_0004);
    chk("wd_late_instret", instret, 1);

    do_reset();
    tick();
    ifu_rsp_valid = 1'b1;
    ifu_rsp_inst  = ADDI;
    tick();
    clr_in();
    exu_done  = 1'b1;
    exu_wen   = 1'b1;
    exu_rd    = 5'd9;
    exu_wdata = 64'h99;
    rst       = 1'b1;
    tick();
    clr_in();
    rst = 1'b0;
    chk("mid_rfwen", rf_wen, 0);
    chk("mid_waddr", rf_waddr, 0);
    chk("mid_exu", exu_valid, 0);
    chk("mid_exupc", exu_pc, 0);
    chk("mid_req", ifu_req_valid, 0);
    chk("mid_instret", instret, 0);
    tick();
    chk("mid_fetch", ifu_req_addr, 64'h8000_0000);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/ysyx_22050550_exctrl.md
YSYX_22050550_EXCTRL -- requirements
Module: ysyx_22050550_exctrl

Interface
REQ-001 Parameter RESET_PC, 64'h8000_0000, PC loaded on reset.
REQ-002 Parameter WDOG_MAX, 8'd255, cycles allowed in FETCH or EXEC before error.
REQ-003 clk  in  1  single clock; all state updates on rising edge.
REQ-004 rst  in  1  synchronous active-high reset.
REQ-005 ifu_req_valid out 1, fetch request; ifu_req_addr out 64, fetch PC.
REQ-006 ifu_rsp_valid in 1, fetch data valid; ifu_rsp_inst in 32, fetched instruction.
REQ-007 exu_valid out 1, instruction issued; exu_pc out 64; exu_instr out 32.
REQ-008 exu_done in 1, EXU result valid; exu_wen in 1; exu_rd in 5; exu_wdata in 64; exu_ebreak in 1.
REQ-009 exu_jmp in 1, redirect taken; exu_jmp_target in 64, redirect PC.
REQ-010 rf_wen out 1; rf_waddr out 5; rf_wdata out 64, register-file write port.
REQ-011 halt out 1, ebreak reached; err out 1, watchdog or misaligned target; instret out 64, retired count.

Function
REQ-012 FSM states SHALL be IDLE, FETCH, EXEC, WB, HALT, ERR.
REQ-013 IDLE SHALL last exactly one cycle after reset, then go to FETCH.
REQ-014 FETCH SHALL hold ifu_req_valid=1 and ifu_req_addr=pc until ifu_rsp_valid=1, then latch ifu_rsp_inst and go to EXEC next cycle.
REQ-015 EXEC SHALL hold exu_valid=1 with latched pc/instr until exu_done=1, including a done in the first EXEC cycle.
REQ-016 On exu_done, EXEC SHALL latch wen, rd, wdata, jmp, target. If exu_ebreak=1, it SHALL go to HALT; otherwise it SHALL go to WB.
REQ-017 WB SHALL last one cycle. It SHALL assert rf_wen = latched wen AND rd!=0, drive rf_waddr/rf_wdata from the latch, and increment instret.
REQ-018 WB SHALL update pc to the latched target if jmp=1, else pc+4 modulo 2^64, then go to FETCH.
REQ-019 A jmp target with bits[1:0]!=0 SHALL send the FSM to ERR in place of WB. It SHALL produce no rf write, and pc and instret SHALL stay unchanged.
REQ-020 On ebreak, instret SHALL increment once and rf_wen SHALL stay 0. halt SHALL assert the cycle HALT is entered and remain 1 until rst.
REQ-021 The watchdog SHALL clear on entry to FETCH/EXEC and count each cycle spent there. Reaching WDOG_MAX without rsp/done SHALL go to ERR.
REQ-022 ERR SHALL assert err sticky until rst. HALT and ERR SHALL issue no requests and ignore all inputs.
REQ-023 ifu_rsp_valid outside FETCH and exu_done outside EXEC SHALL be ignored.
REQ-024 exu_valid, ifu_req_valid and rf_wen SHALL never be high in the same cycle.
REQ-025 Minimum instruction period SHALL be 3 cycles (FETCH, EXEC, WB) with same-cycle rsp and done.

Reset
REQ-026 rst=1 at any edge SHALL force IDLE next cycle, overriding any state including HALT/ERR and mid-handshake.
REQ-027 Reset values: pc=RESET_PC, instret=0, watchdog=0, latches=0, all valid/wen/halt/err outputs 0, address/data outputs 0.

Structure
REQ-028 State encodings, RESET_PC and WDOG_MAX defaults, and PC/inst/register widths SHALL live in the shared ysyx_22050550 define file.
REQ-029 One sub-module, ysyx_22050550_wdog, SHALL hold the watchdog counter. Its ports SHALL be clk, rst, clear, enable and expired.
REQ-030 All outputs SHALL be driven from registers or from decode of the registered state only, with no combinational input-to-output paths.

Verification
REQ-031 Reset, then rsp_valid in first FETCH with inst=addi, done+wen, rd=5, wdata=7. Required: ifu_req_addr=0x80000000; rf_wen pulse with waddr=5, wdata=7 on cycle 4; instret=1; next fetch addr 0x80000004.
REQ-032 rd=0 with wen=1 -> rf_wen stays 0, instret increments, pc advances by 4.
REQ-033 jmp=1 with target 0x80000100 -> next ifu_req_addr=0x80000100. target 0x80000102 -> err=1, pc stays, no rf write.
REQ-034 ebreak on done -> halt=1, instret+1, no further ifu_req_valid over 20 cycles; then rst -> halt=0, fetch at 0x80000000.
REQ-035 Withhold ifu_rsp_valid -> err=1 exactly WDOG_MAX cycles after FETCH entry. A delayed rsp at WDOG_MAX-1 proceeds normally.
REQ-036 rst asserted mid-EXEC with done high that cycle -> no rf write, IDLE next cycle, all outputs at reset values.
